// File: rtl/spi_slave_top.sv
// spi_slave_top: Wishbone SPI slave, oversampled SCLK/SS_n/MOSI, 32-bit chars.
// Optional macro SPI_SLAVE_OVERRUN_EN adds the sticky STATUS[3] overrun flag.
module spi_slave_top #(
  parameter int CHAR_MAX    = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic        wb_clk_in,
  input  logic        wb_rst_in,
  input  logic [4:0]  wb_adr_in,
  input  logic [31:0] wb_dat_in,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_in,
  input  logic        wb_we_in,
  input  logic        wb_stb_in,
  input  logic        wb_cyc_in,
  output logic        wb_ack_out,
  output logic        wb_int_o,
  input  logic        sclk_in,
  input  logic        ss_pad_in,
  input  logic        mosi_in,
  output logic        miso_out,
  output logic        miso_oe
);

  localparam int CW = $clog2(CHAR_MAX + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic sclk_s, ss_s, mosi_s, sclk_d, ss_d;
  logic smp_edge, tx_edge, ss_fall;

  logic [4:0] char_len;
  logic rx_neg, tx_neg, lsb, ie, en;

  logic [CHAR_MAX-1:0] rx_reg, tx_reg, rx_sr, tx_sr;
  logic [CHAR_MAX-1:0] ld_word, ld_al, tx_next, rx_mask;
  logic [CW-1:0] cnt, len, pad;
  logic rx_full, tx_empty, ovr, tx_arm;
  logic load, done, shift, txsh;

  logic acc, wr, rd, wr_tx, wr_ctrl, wr_stat, rd_rx;
  logic [31:0] rdata;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign smp_edge = rx_neg ? (~sclk_s & sclk_d) : (sclk_s & ~sclk_d);
  assign tx_edge  = tx_neg ? (~sclk_s & sclk_d) : (sclk_s & ~sclk_d);
  assign ss_fall  = ~ss_s & ss_d;

  assign miso_oe = en & ~ss_s;

  assign len = (char_len == 5'd0) ? CW'(CHAR_MAX) : CW'(char_len);
  assign pad = CW'(CHAR_MAX) - len;
  assign rx_mask = (len == CW'(CHAR_MAX)) ? {CHAR_MAX{1'b1}}
                 : ((CHAR_MAX'(1) << len) - CHAR_MAX'(1));

  assign ld_word = tx_empty ? '0 : tx_reg;
  assign ld_al   = lsb ? ld_word : (ld_word << pad);
  assign tx_next = lsb ? (tx_sr >> 1) : (tx_sr << 1);

  // Until the first sample edge, an opposite-edge tx strobe is the
  // trailing edge of the previous character and must not shift.
  assign shift = (state == SHIFT) & ~ss_s & smp_edge;
  assign txsh  = (state == SHIFT) & ~ss_s & tx_edge & (tx_arm | smp_edge);

  assign acc     = wb_cyc_in & wb_stb_in & ~wb_ack_out;
  assign wr      = acc & wb_we_in;
  assign rd      = acc & ~wb_we_in;
  assign wr_tx   = wr & (wb_adr_in == 5'h04);
  assign wr_ctrl = wr & (wb_adr_in == 5'h10) & (state == IDLE) & ~load;
  assign wr_stat = wr & (wb_adr_in == 5'h14);
  assign rd_rx   = rd & (wb_adr_in == 5'h00);

  // Pad synchronizers plus one delayed sample for edge detection.
  always_ff @(posedge wb_clk_in or posedge wb_rst_in) begin
    if (wb_rst_in) begin
      sclk_sync <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      ss_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_pad_in};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_in};
      sclk_d    <= sclk_s;
      ss_d      <= ss_s;
    end
  end

  // FSM state register.
  always_ff @(posedge wb_clk_in or posedge wb_rst_in) begin
    if (wb_rst_in) state <= IDLE;
    else           state <= state_nxt;
  end

  // FSM next state, character-start load and completion strobes.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (en && ss_fall) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (ss_s)
          state_nxt = IDLE;
        else if (smp_edge && cnt == CW'(1))
          state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (!ss_s) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift datapath: TX/RX shift registers, bit counter, miso driver.
  always_ff @(posedge wb_clk_in or posedge wb_rst_in) begin
    if (wb_rst_in) begin
      tx_sr    <= '0;
      rx_sr    <= '0;
      cnt      <= '0;
      tx_arm   <= 1'b0;
      miso_out <= 1'b0;
    end else if (load) begin
      tx_sr    <= ld_al;
      rx_sr    <= '0;
      cnt      <= len;
      tx_arm   <= 1'b0;
      miso_out <= lsb ? ld_al[0] : ld_al[CHAR_MAX-1];
    end else begin
      if (shift) begin
        rx_sr  <= lsb ? {mosi_s, rx_sr[CHAR_MAX-1:1]}
                      : {rx_sr[CHAR_MAX-2:0], mosi_s};
        cnt    <= cnt - CW'(1);
        tx_arm <= 1'b1;
      end
      if (txsh) begin
        tx_sr    <= tx_next;
        miso_out <= lsb ? tx_next[0] : tx_next[CHAR_MAX-1];
      end
    end
  end

  // Bus-visible registers; completion beats a same-cycle RX read.
  always_ff @(posedge wb_clk_in or posedge wb_rst_in) begin
    if (wb_rst_in) begin
      char_len <= '0;
      {en, ie, lsb, tx_neg, rx_neg} <= '0;
      tx_reg   <= '0;
      rx_reg   <= '0;
      tx_empty <= 1'b1;
      rx_full  <= 1'b0;
      wb_int_o <= 1'b0;
    end else begin
      if (wr_ctrl && wb_sel_in[0]) char_len <= wb_dat_in[4:0];
      if (wr_ctrl && wb_sel_in[1])
        {en, ie, lsb, tx_neg, rx_neg} <= wb_dat_in[12:8];
      if (wr_tx)
        for (int i = 0; i < 4; i++)
          if (wb_sel_in[i]) tx_reg[8*i +: 8] <= wb_dat_in[8*i +: 8];
      if (load)  tx_empty <= 1'b1;
      if (wr_tx) tx_empty <= 1'b0;
      if (rd_rx) begin
        rx_full  <= 1'b0;
        wb_int_o <= 1'b0;
      end
      if (done) begin
        rx_reg  <= lsb ? (rx_sr >> pad) : rx_sr;
        rx_full <= 1'b1;
        if (ie) wb_int_o <= 1'b1;
      end
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  // Sticky overrun: a completion over unread data; write 1 clears.
  always_ff @(posedge wb_clk_in or posedge wb_rst_in) begin
    if (wb_rst_in) ovr <= 1'b0;
    else if (done && rx_full) ovr <= 1'b1;
    else if (wr_stat && wb_sel_in[0] && wb_dat_in[3]) ovr <= 1'b0;
  end
`else
  assign ovr = 1'b0;
  logic unused_stat;
  assign unused_stat = wr_stat;
`endif

  // Read mux.
  always_comb begin
    rdata = '0;
    case (wb_adr_in)
      5'h00: rdata = rx_reg & rx_mask;
      5'h04: rdata = tx_reg;
      5'h10: rdata = {19'b0, en, ie, lsb, tx_neg, rx_neg, 3'b0, char_len};
      5'h14: rdata = {28'b0, ovr, (state != IDLE), tx_empty, rx_full};
      default: rdata = '0;
    endcase
  end

  // Wishbone ack and registered read data.
  always_ff @(posedge wb_clk_in or posedge wb_rst_in) begin
    if (wb_rst_in) begin
      wb_ack_out <= 1'b0;
      wb_dat_o   <= '0;
    end else begin
      wb_ack_out <= wb_cyc_in & wb_stb_in & ~wb_ack_out;
      if (rd) wb_dat_o <= rdata;
    end
  end

endmodule
